// File: rtl/avalon_st_timing_adapter_fifo_if.sv
// Avalon-ST stream bundle for the timing adapter: an upstream side with no ready
// and a downstream side with ready latency 0.
interface avalon_st_timing_adapter_fifo_if #(
  parameter int DATA_W = 72
);
  // Upstream: in_valid is a push with no backpressure path.
  // Downstream: a beat transfers on any clock edge where out_valid && out_ready.
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  in_data,
    input  in_valid,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_data,
    output in_valid,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/avalon_st_timing_adapter_fifo.sv
// Avalon-ST timing adapter: FWFT buffer between a non-stallable source and a ready sink.
// Optional dropped-beat counter port ovf_count is enabled by TIMING_ADAPTER_OVF_CNT_EN.
module avalon_st_timing_adapter_fifo #(
  parameter int DATA_W         = 72,
  parameter int DEPTH          = 8,
  parameter int ALMOST_FULL_TH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  avalon_st_timing_adapter_fifo_if.slave st,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clr_overflow
`ifdef TIMING_ADAPTER_OVF_CNT_EN
  ,
  output logic [15:0]              ovf_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              read;
  logic              write;
  logic              drop;

  assign empty = (fill_level == '0);
  assign full  = (fill_level == LVL_FULL);

  // A read frees its slot in the same cycle, so a full buffer being drained still accepts.
  assign read  = ~empty & st.out_ready;
  assign write = st.in_valid & (~full | read);
  assign drop  = st.in_valid & ~write;

  assign st.out_valid = ~empty;
  assign st.out_data  = empty ? '0 : mem[rd_ptr];
  assign almost_full  = (fill_level >= LVL_AF);

  // Storage is deliberately not reset; clearing the level discards whatever it holds.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= st.in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (read) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (write && !read) begin
        fill_level <= fill_level + LVL_ONE;
      end else if (read && !write) begin
        fill_level <= fill_level - LVL_ONE;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

`ifdef TIMING_ADAPTER_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_count <= '0;
    end else if (clr_overflow) begin
      ovf_count <= drop ? 16'd1 : 16'd0;
    end else if (drop && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule
